// File: rtl/design_variables.sv
// Shared accelerator widths used by the traceback output path.
// The LIFO depth derives from the sequence length.
package design_variables;
    localparam int LETTER_WIDTH  = 2;
    localparam int SCORE_WIDTH   = 8;
    localparam int SEQ_LENGTH    = 32;
    localparam int GAP_BIT       = LETTER_WIDTH;
    localparam int MAX_ALIGN_LEN = 2 * SEQ_LENGTH;
endpackage

// File: rtl/symbol_lifo.sv
// Register-array LIFO holding query/database symbol pairs.
// Read of the top entry is combinational; pushes when full are discarded.
module symbol_lifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 64,
    parameter int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W-1:0] ptr,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full   = (ptr == PTR_W'(DEPTH));
    assign empty  = (ptr == '0);
    assign wr_idx = ptr[AW-1:0];
    assign rd_idx = ptr[AW-1:0] - AW'(1);
    assign dout   = mem[rd_idx];

    // Stack pointer: clear wins, then push, then pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PTR_W'(1);
        end
    end

    // Entry storage written at the current pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full && !clr) begin
            mem[wr_idx] <= din;
        end
    end
endmodule

// File: rtl/alignment_output_collector.sv
// Collects the reversed traceback stream into a LIFO and replays it
// in forward alignment order with score and length.
import design_variables::*;

module alignment_output_collector #(
    parameter int LETTER_WIDTH  = design_variables::LETTER_WIDTH,
    parameter int SCORE_WIDTH   = design_variables::SCORE_WIDTH,
    parameter int MAX_ALIGN_LEN = design_variables::MAX_ALIGN_LEN,
    parameter int LEN_W         = $clog2(MAX_ALIGN_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [LETTER_WIDTH:0]   in_query,
    input  logic [LETTER_WIDTH:0]   in_database,
    input  logic [SCORE_WIDTH-1:0]  in_score,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LETTER_WIDTH:0]   out_query,
    output logic [LETTER_WIDTH:0]   out_database,
    output logic                    out_last,
    output logic [SCORE_WIDTH-1:0]  out_score,
    output logic [LEN_W-1:0]        out_len,
    output logic                    busy,
    output logic                    overflow,
    output logic                    dropped
);
    localparam int SYM_W = LETTER_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t             state;
    state_t             next_state;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [LEN_W-1:0]   ptr;
    logic [2*SYM_W-1:0] top;

    symbol_lifo #(
        .WIDTH (2 * SYM_W),
        .DEPTH (MAX_ALIGN_LEN),
        .PTR_W (LEN_W)
    ) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .din   ({in_query, in_database}),
        .dout  (top),
        .ptr   (ptr),
        .full  (full),
        .empty (empty)
    );

    assign out_valid    = (state == DRAIN);
    assign out_last     = out_valid && (ptr == LEN_W'(1));
    assign busy         = (state != IDLE);
    assign out_query    = out_valid ? top[2*SYM_W-1:SYM_W] : '0;
    assign out_database = out_valid ? top[SYM_W-1:0] : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and LIFO push/pop; start overrides everything
    always_comb begin
        next_state = state;
        push       = 1'b0;
        pop        = 1'b0;
        if (start) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        push       = 1'b1;
                        next_state = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        push = 1'b1;
                    end else begin
                        next_state = DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready && !empty) begin
                        pop = 1'b1;
                        if (ptr == LEN_W'(1)) begin
                            next_state = IDLE;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Score/length latches and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_score <= '0;
            out_len   <= '0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else if (start) begin
            out_score <= '0;
            out_len   <= '0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                out_score <= in_score;
            end
            if (state == CAPTURE && !in_valid) begin
                out_len <= ptr;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (state == DRAIN && in_valid) begin
                dropped <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alignment_output_collector.sv
// Scoreboard bench for alignment_output_collector.
// Expected forward-order pairs are queued at stimulus time.
module tb_alignment_output_collector;
    localparam int LW  = 2;
    localparam int SW  = 8;
    localparam int MAX = 64;
    localparam int LNW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [LW:0]   in_query = '0;
    logic [LW:0]   in_database = '0;
    logic [SW-1:0] in_score = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [LW:0]   out_query;
    logic [LW:0]   out_database;
    logic          out_last;
    logic [SW-1:0] out_score;
    logic [LNW-1:0] out_len;
    logic          busy;
    logic          overflow;
    logic          dropped;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;

    logic [6:0] exp_q [$];
    logic [2:0] bq [$];
    logic [2:0] bd [$];

    localparam logic [2:0] A = 3'b000;
    localparam logic [2:0] C = 3'b001;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] T = 3'b011;
    localparam logic [2:0] GAP = 3'b100;

    alignment_output_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_query     (in_query),
        .in_database  (in_database),
        .in_score     (in_score),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_query    (out_query),
        .out_database (out_database),
        .out_last     (out_last),
        .out_score    (out_score),
        .out_len      (out_len),
        .busy         (busy),
        .overflow     (overflow),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Handshakes are sampled mid-cycle and matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && !start && out_valid && out_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                check("unexpected_pair", 32'({out_last, out_query, out_database}), 32'h7f);
            end else begin
                check("pair", 32'({out_last, out_query, out_database}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_burst(input logic [SW-1:0] sc);
        int n;
        int stored;
        n = bq.size();
        stored = (n > MAX) ? MAX : n;
        for (int i = stored - 1; i >= 0; i--) begin
            exp_q.push_back({(i == 0), bq[i], bd[i]});
        end
        for (int i = 0; i < n; i++) begin
            in_valid    = 1'b1;
            in_query    = bq[i];
            in_database = bd[i];
            in_score    = (i == 0) ? sc : ~sc;
            tick();
        end
        in_valid = 1'b0;
        in_query = '0;
        in_database = '0;
        tick();
        bq.delete();
        bd.delete();
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int hs0;
        logic [2:0] pat [5];
        pat[0] = 3'b001; pat[1] = 3'b000; pat[2] = 3'b000;
        pat[3] = 3'b001; pat[4] = 3'b001;

        #2;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_len", 32'(out_len), 0);
        check("rst_score", 32'(out_score), 0);
        check("rst_flags", 32'({overflow, dropped, out_last}), 0);
        #10;
        rst_n = 1'b1;
        tick();

        // Basic three-pair burst, host always ready
        bq = '{T, G, A};
        bd = '{T, GAP, A};
        hs0 = n_hs;
        send_burst(8'd5);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_len", 32'(out_len), 3);
        check("t1_score", 32'(out_score), 5);
        tick(); tick(); tick();
        check("t1_hs", 32'(n_hs - hs0), 3);
        check("t1_busy", 32'(busy), 0);
        check("t1_valid_end", 32'(out_valid), 0);

        // Same burst with back-pressure
        bq = '{T, G, A};
        bd = '{T, GAP, A};
        hs0 = n_hs;
        out_ready = 1'b1;
        send_burst(8'd5);
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i][0];
            #1;
            if (!out_ready && exp_q.size() != 0) begin
                check("stall_hold",
                      32'({out_last, out_query, out_database}),
                      32'(exp_q[0]));
            end
            tick();
        end
        out_ready = 1'b1;
        check("t2_hs", 32'(n_hs - hs0), 3);
        check("t2_busy", 32'(busy), 0);

        // Overflow: 66 symbols into a 64-deep LIFO
        for (int i = 0; i < 66; i++) begin
            bq.push_back(3'(i % 5));
            bd.push_back(3'((i * 3 + 1) % 5));
        end
        hs0 = n_hs;
        send_burst(8'd200);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_len", 32'(out_len), 64);
        check("ovf_score", 32'(out_score), 200);
        wait_idle("ovf_drain_done");
        check("ovf_hs", 32'(n_hs - hs0), 64);

        // in_valid during drain is dropped
        start = 1'b1; tick(); start = 1'b0;
        check("start_clr_ovf", 32'(overflow), 0);
        bq = '{C, A, G};
        bd = '{GAP, T, G};
        hs0 = n_hs;
        send_burst(8'd9);
        in_valid = 1'b1;
        in_query = T;
        in_database = T;
        tick();
        in_valid = 1'b0;
        wait_idle("drop_drain_done");
        check("drop_hs", 32'(n_hs - hs0), 3);
        check("drop_flag", 32'(dropped), 1);
        start = 1'b1; tick(); start = 1'b0;
        check("drop_clr", 32'(dropped), 0);

        // start on second handshake aborts a 5-pair drain
        bq = '{A, C, G, T, A};
        bd = '{C, G, T, A, GAP};
        send_burst(8'd17);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_len", 32'(out_len), 0);
        check("abort_left", 32'(exp_q.size()), 4);
        exp_q.delete();
        bq = '{G, T};
        bd = '{GAP, C};
        hs0 = n_hs;
        send_burst(8'd3);
        check("post_abort_len", 32'(out_len), 2);
        wait_idle("post_abort_done");
        check("post_abort_hs", 32'(n_hs - hs0), 2);

        // Asynchronous reset during capture
        in_valid = 1'b1; in_query = C; in_database = C; in_score = 8'd44;
        tick();
        in_query = G;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_outs", 32'({out_valid, out_last, overflow, dropped}), 0);
        check("arst_score_len", 32'({out_score, out_len}), 0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        bq = '{T};
        bd = '{GAP};
        hs0 = n_hs;
        out_ready = 1'b0;
        send_burst(8'd1);
        check("one_last", 32'(out_last), 1);
        check("one_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        wait_idle("one_done");
        check("one_hs", 32'(n_hs - hs0), 1);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alignment_output_collector.md
# alignment_output_collector

Receives the reversed traceback symbol stream produced at the end of an alignment (last aligned position first), stores it in an internal LIFO, and replays it to the host in forward alignment order over a valid/ready stream with the alignment score and length. Sits between the accelerator's `query_seq_out`/`database_seq_out`/`score`/`output_valid` outputs and the host read-out logic. It is the receiving end of the traceback output interface.

## Interface
- `LETTER_WIDTH`, 2: bits per letter; a symbol is `LETTER_WIDTH+1` bits, and bit `[LETTER_WIDTH]`=1 means gap.
- `SCORE_WIDTH`, 8: alignment score width.
- `MAX_ALIGN_LEN`, 64: LIFO depth, equal to 2×SEQ_LENGTH.
- `LEN_W`, $clog2(MAX_ALIGN_LEN+1): length counter width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: new-job pulse; aborts any activity and clears sticky flags.
- `in_valid` in 1: traceback symbol valid (driven by `output_valid`).
- `in_query` in LETTER_WIDTH+1: query symbol.
- `in_database` in LETTER_WIDTH+1: database symbol.
- `in_score` in SCORE_WIDTH: final max score.
- `out_valid` out 1: forward-order symbol pair available.
- `out_ready` in 1: host accepts.
- `out_query` out LETTER_WIDTH+1: query symbol, forward order.
- `out_database` out LETTER_WIDTH+1: database symbol, forward order.
- `out_last` out 1: final pair of the alignment.
- `out_score` out SCORE_WIDTH: score latched from the burst.
- `out_len` out LEN_W: number of stored pairs.
- `busy` out 1: state ≠ IDLE.
- `overflow` out 1: sticky flag; a symbol was dropped because the LIFO was full.
- `dropped` out 1: sticky flag; `in_valid` arrived during DRAIN.

## Operation
- Reset values: state IDLE, pointer 0, `out_valid`/`out_last`/`busy`/`overflow`/`dropped` 0, `out_score` 0, `out_len` 0.
- States:
  - IDLE: `in_valid`=1 → push, latch `in_score`, → CAPTURE.
  - CAPTURE: each `in_valid` cycle pushes a pair. `in_valid`=0 → DRAIN.
  - DRAIN: `out_valid`=1, and the output is the top of the LIFO (entry ptr−1). On `out_valid&&out_ready`, pop. The handshake with ptr==1 also → IDLE.
- Push when ptr==MAX_ALIGN_LEN: the pair is discarded, `overflow`←1, ptr holds. The stored pairs are still drained; `out_len`=MAX_ALIGN_LEN.
- `out_len` = ptr at the CAPTURE→DRAIN transition. It is held until the next capture begins.
- `out_last` = `out_valid && ptr==1`.
- `in_valid` during DRAIN: the symbol is ignored and `dropped`←1. The drain continues.
- `start` has priority over every other event in any state: ptr←0, state←IDLE, `overflow`/`dropped`←0, `out_score`/`out_len`←0. An `in_valid` in the same cycle is ignored.
- `in_score` is sampled only on the first `in_valid` of a burst.
- Asynchronous reset mid-DRAIN: all outputs return immediately to their reset values. No partial stream resumes.
- Symbols are never interpreted, except that a gap symbol passes through unchanged.

## Timing
- Push is registered: a pair at cycle t is stored by the edge ending t.
- The first `in_valid`=0 is sampled at cycle t. At t+1 the state is DRAIN and `out_valid`=1 with the last-captured pair.
- Throughput is one pair per cycle while `out_ready`=1. `out_*` is stable while `out_valid && !out_ready`.
- After the final handshake (cycle u), `out_valid`=0 and `busy`=0 at u+1.
- A one-cycle burst yields a single pair with `out_last`=1 on the first DRAIN cycle.
- LIFO read is combinational from the register array. There are no other combinational input→output paths except `out_last`/`out_valid` from state.

## Structure
- The shared design_variables package holds `LETTER_WIDTH`, `SCORE_WIDTH`, `SEQ_LENGTH` and the gap-bit position. `MAX_ALIGN_LEN` is derived as 2×SEQ_LENGTH.
- The state enum (IDLE/CAPTURE/DRAIN) is local.
- One sub-module, `symbol_lifo`: push/pop, pointer, full/empty, storage of 2×(LETTER_WIDTH+1) bits per entry.
- The FSM, score/length latches and sticky flags live in the top of this block.

## Test plan
- Encoding: A=000, C=001, G=010, T=011, gap=100.
- Burst (q,d) = (T,T),(G,gap),(A,A), score 5, `out_ready`=1 → outputs (A,A),(G,gap),(T,T) on three consecutive cycles. `out_last` is set on the third; `out_len`=3, `out_score`=5, `busy`=0 afterwards.
- Same burst with `out_ready` toggling 1,0,0,1,1 → the pair is held during the stalls, there is no duplication or skip, and three handshakes total.
- 66 consecutive `in_valid` cycles with MAX_ALIGN_LEN=64 → `overflow`=1 and `out_len`=64. 64 pairs are drained, starting with the 64th captured.
- `in_valid` pulse during DRAIN → `dropped`=1, the drain sequence is unchanged. A following `start` clears `dropped`.
- `start` asserted on the 2nd DRAIN handshake of a 5-pair alignment → next cycle `out_valid`=0, `busy`=0, `out_len`=0. A new 2-pair burst then drains correctly.
- `rst_n` low asynchronously mid-CAPTURE → all outputs are 0 immediately. After release, a 1-pair burst yields `out_last`=1 one cycle after `in_valid` falls.
